// File: rtl/pwm_timebase.sv
// Shared up-counting PWM timebase: prescaled counter 0..top with shadowed top/prescale.
// Optional one-shot mode is compiled in with `define PWM_TIMEBASE_ONESHOT_EN (adds the oneShot input).
module pwm_timebase #(
   parameter int WIDTH          = 16,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   input  logic [WIDTH-1:0]          topValue,
`ifdef PWM_TIMEBASE_ONESHOT_EN
   input  logic                      oneShot,
`endif
   output logic [WIDTH-1:0]          counterValue,
   output logic                      tick,
   output logic                      periodStart,
   output logic                      running
);

   localparam logic [WIDTH-1:0]          CNT_ONE = WIDTH'(1);
   localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1);

   logic [WIDTH-1:0]          counter_reg, counter_next;
   logic [PRESCALE_WIDTH-1:0] prescale_count_reg, prescale_count_next;
   logic [PRESCALE_WIDTH-1:0] current_prescale_reg, current_prescale_next;
   logic [WIDTH-1:0]          current_top_reg, current_top_next;
   logic                      last_enable_reg, last_enable_next;
   logic                      tick_reg, tick_next;
   logic                      period_start_reg, period_start_next;
   logic                      running_reg, running_next;

   // Enabled but not running only happens after a one-shot period has completed.
   logic hold;
   assign hold = last_enable_reg && !running_reg;

   always_comb begin
      counter_next          = counter_reg;
      prescale_count_next   = prescale_count_reg;
      current_prescale_next = current_prescale_reg;
      current_top_next      = current_top_reg;
      last_enable_next      = last_enable_reg;
      tick_next             = 1'b0;
      period_start_next     = 1'b0;
      running_next          = running_reg;

      if (!enable) begin
         counter_next          = '0;
         prescale_count_next   = '0;
         running_next          = 1'b0;
         last_enable_next      = 1'b0;
         current_top_next      = topValue;
         current_prescale_next = prescale;
      end else if (!last_enable_reg) begin
         // First enabled cycle opens a period without stepping the counter.
         counter_next        = '0;
         prescale_count_next = '0;
         period_start_next   = 1'b1;
         running_next        = 1'b1;
         last_enable_next    = 1'b1;
      end else if (hold) begin
         counter_next        = '0;
         prescale_count_next = '0;
      end else if (prescale_count_reg == current_prescale_reg) begin
         prescale_count_next = '0;
         tick_next           = 1'b1;
         if (counter_reg >= current_top_reg) begin
            counter_next          = '0;
            current_top_next      = topValue;
            current_prescale_next = prescale;
            period_start_next     = 1'b1;
`ifdef PWM_TIMEBASE_ONESHOT_EN
            if (oneShot) begin
               period_start_next = 1'b0;
               running_next      = 1'b0;
            end
`endif
         end else begin
            counter_next = counter_reg + CNT_ONE;
         end
      end else begin
         prescale_count_next = prescale_count_reg + PRE_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         counter_reg          <= '0;
         prescale_count_reg   <= '0;
         current_prescale_reg <= '0;
         current_top_reg      <= '0;
         last_enable_reg      <= 1'b0;
         tick_reg             <= 1'b0;
         period_start_reg     <= 1'b0;
         running_reg          <= 1'b0;
      end else begin
         counter_reg          <= counter_next;
         prescale_count_reg   <= prescale_count_next;
         current_prescale_reg <= current_prescale_next;
         current_top_reg      <= current_top_next;
         last_enable_reg      <= last_enable_next;
         tick_reg             <= tick_next;
         period_start_reg     <= period_start_next;
         running_reg          <= running_next;
      end
   end

   assign counterValue = counter_reg;
   assign tick         = tick_reg;
   assign periodStart  = period_start_reg;
   assign running      = running_reg;

endmodule

// File: tb/tb_pwm_timebase.sv
// Scoreboard bench for pwm_timebase: a period-position model predicts every cycle's outputs.
module tb_pwm_timebase;

   localparam int W  = 16;
   localparam int PW = 8;

   logic          clk = 1'b0;
   logic          rst, enable, one_shot;
   logic [PW-1:0] prescale;
   logic [W-1:0]  top_value;
   logic [W-1:0]  counter_value;
   logic          tick, period_start, running;

   always #5 clk = ~clk;

   pwm_timebase #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
      .clk(clk), .rst(rst), .enable(enable), .prescale(prescale), .topValue(top_value),
`ifdef PWM_TIMEBASE_ONESHOT_EN
      .oneShot(one_shot),
`endif
      .counterValue(counter_value), .tick(tick), .periodStart(period_start), .running(running)
   );

   typedef struct {
      int         cyc;
      logic [W-1:0] cnt;
      logic       tck;
      logic       ps;
      logic       run;
   } exp_t;

   exp_t exp_q[$];
   int total = 0;
   int bad   = 0;
   int cyc_no = 0;

   // Model: position t (clk cycles) inside the current period; counter and strobes follow by arithmetic.
   longint m_t;
   longint m_top, m_pre;
   bit     m_prev_en, m_first, m_done;

   task automatic model_step(output exp_t e);
      longint len;
      e.cyc = cyc_no; e.cnt = '0; e.tck = 1'b0; e.ps = 1'b0; e.run = 1'b0;
      if (rst) begin
         m_prev_en = 0; m_top = 0; m_pre = 0; m_done = 0;
      end else if (!enable) begin
         m_prev_en = 0; m_top = top_value; m_pre = prescale; m_done = 0;
      end else if (!m_prev_en) begin
         m_prev_en = 1; m_t = 0; m_first = 1; m_done = 0;
         e.ps = 1'b1; e.run = 1'b1;
      end else if (m_done) begin
         // held after a one-shot period: all outputs low
      end else begin
         len = (m_top + 1) * (m_pre + 1);
         m_t = m_t + 1;
         if (m_t == len) begin
            m_t = 0; m_first = 0;
`ifdef PWM_TIMEBASE_ONESHOT_EN
            if (one_shot) m_done = 1;
`endif
            m_top = top_value; m_pre = prescale;
         end
         if (m_done) begin
            e.tck = 1'b1;
         end else begin
            e.cnt = W'(m_t / (m_pre + 1));
            e.tck = ((m_t % (m_pre + 1)) == 0) && !(m_first && m_t == 0);
            e.ps  = (m_t == 0);
            e.run = 1'b1;
         end
      end
   endtask

   task automatic drive(input bit r, input bit en, input int pre, input int top, input bit os, input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         rst = r; enable = en; prescale = PW'(pre); top_value = W'(top); one_shot = os;
         model_step(e);
         exp_q.push_back(e);
         @(posedge clk);
         @(negedge clk);
         cyc_no++;
      end
   endtask

   // Monitor: one expected entry per clock edge, compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            total++;
            if (counter_value !== e.cnt) begin
               bad++;
               $display("FAIL counterValue cyc=%0d got=%0d exp=%0d", e.cyc, counter_value, e.cnt);
            end
            total++;
            if (tick !== e.tck) begin
               bad++;
               $display("FAIL tick cyc=%0d got=%0b exp=%0b", e.cyc, tick, e.tck);
            end
            total++;
            if (period_start !== e.ps) begin
               bad++;
               $display("FAIL periodStart cyc=%0d got=%0b exp=%0b", e.cyc, period_start, e.ps);
            end
            total++;
            if (running !== e.run) begin
               bad++;
               $display("FAIL running cyc=%0d got=%0b exp=%0b", e.cyc, running, e.run);
            end
            $display("cyc=%0d cnt=%0d tick=%0b ps=%0b run=%0b", e.cyc, counter_value, tick, period_start, running);
         end
      end
   end

   initial begin
      bit en_r;
      int pre_r, top_r;
      bit os_r;
      m_t = 0; m_top = 0; m_pre = 0; m_prev_en = 0; m_first = 0; m_done = 0;
      rst = 1'b1; enable = 1'b0; prescale = '0; top_value = '0; one_shot = 1'b0;
      @(negedge clk);

      drive(1, 0, 0, 3, 0, 3);            // reset state
      drive(0, 1, 0, 3, 0, 12);           // prescale 0, top 3
      drive(0, 0, 2, 1, 0, 1);
      drive(0, 1, 2, 1, 0, 14);           // prescale 2, top 1
      drive(0, 0, 0, 9, 0, 1);
      drive(0, 1, 0, 9, 0, 6);            // count up to 5
      drive(0, 1, 0, 4, 0, 16);           // top change takes effect after wrap
      drive(0, 0, 1, 0, 0, 1);
      drive(0, 1, 1, 0, 0, 8);            // top 0, prescale 1
      drive(0, 0, 0, 15, 0, 1);
      drive(0, 1, 0, 15, 0, 8);           // count reaches 7
      drive(0, 0, 0, 15, 0, 2);           // drop enable
      drive(0, 1, 0, 15, 0, 6);           // re-enable
      drive(1, 1, 0, 15, 0, 1);           // reset mid-count
      drive(0, 1, 0, 15, 0, 4);
`ifdef PWM_TIMEBASE_ONESHOT_EN
      drive(0, 0, 0, 2, 1, 1);
      drive(0, 1, 0, 2, 1, 10);           // one-shot run then hold
      drive(0, 0, 0, 2, 1, 1);
      drive(0, 1, 0, 2, 0, 8);            // runs again
`endif

      en_r = 1; pre_r = 1; top_r = 5; os_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(19, 0) == 0) top_r = $urandom_range(12, 0);
         if ($urandom_range(24, 0) == 0) pre_r = $urandom_range(3, 0);
         if (en_r) begin
            if ($urandom_range(59, 0) == 0) en_r = 0;
         end else if ($urandom_range(3, 0) == 0) begin
            en_r = 1;
         end
         os_r = ($urandom_range(29, 0) == 0);
         drive(($urandom_range(299, 0) == 0), en_r, pre_r, top_r, os_r, 1);
      end

      @(posedge clk);
      #2;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
